// File: rtl/mac_chain_sched_pkg.sv
// Shared hyper-parameters and state encoding for the MAC-chain tile sequencer.
package mac_chain_sched_pkg;
    localparam int QUAN_BITS = 8;
    localparam int KTAPS     = 9;
    localparam int PIX_W     = 16;
    localparam int PE_LAT    = 2;
    localparam int IDX_W     = $clog2(KTAPS);
    // Drain covers the full chain latency plus the cycle the last strobe lands in.
    localparam int DRAIN_CYC = KTAPS * PE_LAT + 1;
    localparam int DRAIN_W   = $clog2(KTAPS * PE_LAT + 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD_W = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;
endpackage

// File: rtl/mac_chain_sched_if.sv
// Weight/feature streams in, broadcast PE-chain bus out.
interface mac_chain_sched_if;
    import mac_chain_sched_pkg::*;

    logic                 s_w_valid;
    logic [QUAN_BITS-1:0] s_w_data;
    logic                 s_w_ready;
    logic                 s_f_valid;
    logic [QUAN_BITS-1:0] s_f_data;
    logic                 s_f_ready;
    logic                 o_pe_clr;
    logic [KTAPS-1:0]     o_k_weight_valid;
    logic [QUAN_BITS-1:0] o_kernel_weight;
    logic                 o_f_data_valid;
    logic [QUAN_BITS-1:0] o_feature_data;

    modport slave (
        input  s_w_valid, s_w_data, s_f_valid, s_f_data,
        output s_w_ready, s_f_ready, o_pe_clr, o_k_weight_valid,
               o_kernel_weight, o_f_data_valid, o_feature_data
    );
    modport master (
        output s_w_valid, s_w_data, s_f_valid, s_f_data,
        input  s_w_ready, s_f_ready, o_pe_clr, o_k_weight_valid,
               o_kernel_weight, o_f_data_valid, o_feature_data
    );
endinterface

// File: rtl/mac_chain_drain_cnt.sv
// Loadable down-counter with a zero flag; load wins over decrement.
module mac_chain_drain_cnt #(
    parameter int W = 5
) (
    input  logic         s_clk,
    input  logic         s_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/mac_chain_sched.sv
// Per-tile sequencer for the MAC PE chain: clear, load KTAPS weights,
// stream the pixels, wait out the chain latency, report done.
module mac_chain_sched
    import mac_chain_sched_pkg::*;
(
    input  logic             s_clk,
    input  logic             s_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [PIX_W-1:0] i_num_pix,
    mac_chain_sched_if.slave bus,
    output logic             o_busy,
    output logic             o_done,
    output logic [PIX_W-1:0] o_pix_cnt
);
    state_e               state_q, state_d;
    logic [PIX_W-1:0]     num_pix_q, num_pix_d;
    logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 pe_clr_q, pe_clr_d;
    logic [KTAPS-1:0]     kwv_q, kwv_d;
    logic [QUAN_BITS-1:0] kw_q, kw_d;
    logic                 fdv_q, fdv_d;
    logic [QUAN_BITS-1:0] fd_q, fd_d;
    logic                 w_ready, f_ready, w_acc, f_acc;
    logic                 drn_load, drn_dec, drn_zero;

    // Abort masks ready so an abandoned word is never handshaken.
    assign w_ready = (state_q == ST_LOAD_W) && !i_abort;
    assign f_ready = (state_q == ST_STREAM) && (pix_cnt_q < num_pix_q) && !i_abort;
    assign w_acc   = bus.s_w_valid && w_ready;
    assign f_acc   = bus.s_f_valid && f_ready;

    always_comb begin
        state_d   = state_q;
        num_pix_d = num_pix_q;
        pix_cnt_d = pix_cnt_q;
        idx_d     = idx_q;
        pe_clr_d  = 1'b0;
        kwv_d     = '0;
        kw_d      = kw_q;
        fdv_d     = 1'b0;
        fd_d      = fd_q;
        drn_dec   = 1'b0;
        if (state_q != ST_IDLE && i_abort) begin
            state_d  = ST_IDLE;
            pe_clr_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (i_start) begin
                    state_d   = ST_CLEAR;
                    num_pix_d = i_num_pix;
                    pix_cnt_d = '0;
                    pe_clr_d  = 1'b1;
                end
                ST_CLEAR: begin
                    state_d = ST_LOAD_W;
                    idx_d   = '0;
                end
                ST_LOAD_W: if (w_acc) begin
                    kwv_d = KTAPS'(1) << idx_q;
                    kw_d  = bus.s_w_data;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(KTAPS - 1))
                        state_d = (num_pix_q == '0) ? ST_DRAIN : ST_STREAM;
                end
                ST_STREAM: if (f_acc) begin
                    fdv_d     = 1'b1;
                    fd_d      = bus.s_f_data;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q + 1'b1 == num_pix_q)
                        state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drn_zero) state_d = ST_DONE;
                    else          drn_dec = 1'b1;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        // Load lands in the cycle the final strobe is visible, so DRAIN spans DRAIN_CYC cycles.
        drn_load = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q   <= ST_IDLE;
            num_pix_q <= '0;
            pix_cnt_q <= '0;
            idx_q     <= '0;
            pe_clr_q  <= 1'b0;
            kwv_q     <= '0;
            kw_q      <= '0;
            fdv_q     <= 1'b0;
            fd_q      <= '0;
        end else begin
            state_q   <= state_d;
            num_pix_q <= num_pix_d;
            pix_cnt_q <= pix_cnt_d;
            idx_q     <= idx_d;
            pe_clr_q  <= pe_clr_d;
            kwv_q     <= kwv_d;
            kw_q      <= kw_d;
            fdv_q     <= fdv_d;
            fd_q      <= fd_d;
        end
    end

    mac_chain_drain_cnt #(.W(DRAIN_W)) u_drain (
        .s_clk    (s_clk),
        .s_rst    (s_rst),
        .load     (drn_load),
        .load_val (DRAIN_W'(DRAIN_CYC - 1)),
        .dec      (drn_dec),
        .zero     (drn_zero)
    );

    assign bus.s_w_ready        = w_ready;
    assign bus.s_f_ready        = f_ready;
    assign bus.o_pe_clr         = pe_clr_q;
    assign bus.o_k_weight_valid = kwv_q;
    assign bus.o_kernel_weight  = kw_q;
    assign bus.o_f_data_valid   = fdv_q;
    assign bus.o_feature_data   = fd_q;
    assign o_busy               = (state_q != ST_IDLE);
    assign o_done               = (state_q == ST_DONE) && !i_abort;
    assign o_pix_cnt            = pix_cnt_q;
endmodule

// File: tb/tb_mac_chain_sched.sv
// Directed bench for mac_chain_sched: table of tile scenarios plus abort and reset sequences.
module tb_mac_chain_sched;
    import mac_chain_sched_pkg::*;

    logic             s_clk = 1'b0;
    logic             s_rst = 1'b0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic [PIX_W-1:0] i_num_pix = '0;
    logic             o_busy, o_done;
    logic [PIX_W-1:0] o_pix_cnt;
    int               n_chk = 0;
    int               n_fail = 0;
    logic [QUAN_BITS-1:0] last_fd = '0;
    logic [QUAN_BITS-1:0] feats [8] = '{8'd10, 8'hFD, 8'd7, 8'd127, 8'h80, 8'd1, 8'hFF, 8'd64};

    mac_chain_sched_if bus ();

    mac_chain_sched dut (
        .s_clk     (s_clk),
        .s_rst     (s_rst),
        .i_start   (i_start),
        .i_abort   (i_abort),
        .i_num_pix (i_num_pix),
        .bus       (bus.slave),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_pix_cnt (o_pix_cnt)
    );

    always #5 s_clk = ~s_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int num_pix;  // pixels per tile
        int w_per;    // weight valid every w_per cycles
        int f_per;    // feature valid every f_per cycles
        bit glitch;   // extra starts during LOAD_W (c=5) and DRAIN (c=20)
        int done_at;  // expected o_done cycle, relative to start cycle 0
    } tile_t;

    tile_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle_inputs();
        i_start = 1'b0; i_abort = 1'b0;
        bus.s_w_valid = 1'b0; bus.s_w_data = '0;
        bus.s_f_valid = 1'b0; bus.s_f_data = '0;
    endtask

    task automatic run_tile(input tile_t t);
        int tap = 0, nf = 0;
        logic w_acc = 1'b0, f_acc = 1'b0;
        logic [KTAPS-1:0] oh;
        for (int c = 0; c <= t.done_at + 3; c++) begin
            i_start       = (c == 0) || (t.glitch && (c == 5 || c == 20));
            i_num_pix     = (c == 0) ? PIX_W'(t.num_pix) : PIX_W'(7);
            bus.s_w_valid = (c % t.w_per) == 0;
            bus.s_w_data  = QUAN_BITS'(tap + 1);
            bus.s_f_valid = (c % t.f_per) == 0;
            bus.s_f_data  = feats[nf % 8];
            @(negedge s_clk);
            oh = '0;
            if (w_acc) oh[tap-1] = 1'b1;
            chk("pe_clr", bus.o_pe_clr, c == 1);
            chk("k_weight_valid", bus.o_k_weight_valid, oh);
            if (w_acc) chk("kernel_weight", bus.o_kernel_weight, tap);
            chk("f_data_valid", bus.o_f_data_valid, f_acc);
            chk("feature_data", bus.o_feature_data, last_fd);
            if (c > 0) chk("pix_cnt", o_pix_cnt, nf);
            chk("done", o_done, c == t.done_at);
            chk("busy", o_busy, c >= 1 && c <= t.done_at);
            w_acc = bus.s_w_valid && bus.s_w_ready;
            f_acc = bus.s_f_valid && bus.s_f_ready;
            if (w_acc) tap++;
            if (f_acc) begin
                last_fd = bus.s_f_data;
                nf++;
            end
            @(posedge s_clk); #1;
        end
        idle_inputs();
        chk("taps_loaded", tap, KTAPS);
        chk("pix_accepted", nf, t.num_pix);
        chk("pix_cnt_final", o_pix_cnt, t.num_pix);
    endtask

    initial begin
        // weights 1..9 at taps accepted c=2..10; strobes c=3..11
        tbl[0] = '{num_pix: 4, w_per: 1, f_per: 1, glitch: 0, done_at: 34}; // last feature strobe c=15
        tbl[1] = '{num_pix: 3, w_per: 2, f_per: 3, glitch: 0, done_at: 47}; // taps c=2..18, pixels c=21,24,27
        tbl[2] = '{num_pix: 0, w_per: 1, f_per: 1, glitch: 0, done_at: 30}; // last weight strobe c=11
        tbl[3] = '{num_pix: 2, w_per: 1, f_per: 1, glitch: 1, done_at: 32}; // last feature strobe c=13
        idle_inputs();

        #1 s_rst = 1'b1;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_pix_cnt", o_pix_cnt, 0);
        chk("rst_pe_clr", bus.o_pe_clr, 0);
        chk("rst_kwv", bus.o_k_weight_valid, 0);
        chk("rst_kw", bus.o_kernel_weight, 0);
        chk("rst_fdv", bus.o_f_data_valid, 0);
        chk("rst_fd", bus.o_feature_data, 0);
        chk("rst_w_ready", bus.s_w_ready, 0);
        chk("rst_f_ready", bus.s_f_ready, 0);
        @(negedge s_clk); s_rst = 1'b0;
        @(posedge s_clk); #1;

        for (int i = 0; i < 4; i++) run_tile(tbl[i]);

        // Abort during STREAM after 2 of 5 pixels, with a feature offered that cycle.
        begin
            int nf = 0, tap = 0;
            for (int c = 0; c <= 13; c++) begin
                i_start       = (c == 0);
                i_num_pix     = PIX_W'(5);
                i_abort       = (c == 13);
                bus.s_w_valid = 1'b1;
                bus.s_w_data  = QUAN_BITS'(tap + 1);
                bus.s_f_valid = 1'b1;
                bus.s_f_data  = feats[nf % 8];
                @(negedge s_clk);
                if (bus.s_w_valid && bus.s_w_ready) tap++;
                if (bus.s_f_valid && bus.s_f_ready) nf++;
                @(posedge s_clk); #1;
            end
            idle_inputs();
            @(negedge s_clk);
            chk("abort_busy", o_busy, 0);
            chk("abort_pe_clr", bus.o_pe_clr, 1);
            chk("abort_fdv", bus.o_f_data_valid, 0);
            chk("abort_done", o_done, 0);
            chk("abort_pix_cnt", o_pix_cnt, 2);
            for (int c = 0; c < 25; c++) begin
                @(negedge s_clk);
                chk("abort_no_done", o_done, 0);
                chk("abort_pe_clr_off", bus.o_pe_clr, 0);
                chk("abort_idle", o_busy, 0);
            end
            @(posedge s_clk); #1;
        end

        // Reset in LOAD_W while tap 5 is being offered.
        begin
            int tap = 0;
            for (int c = 0; c <= 7; c++) begin
                i_start       = (c == 0);
                i_num_pix     = PIX_W'(4);
                bus.s_w_valid = 1'b1;
                bus.s_w_data  = QUAN_BITS'(tap + 1);
                @(negedge s_clk);
                if (c == 7) begin
                    chk("pre_rst_kwv", bus.o_k_weight_valid, 9'h010);
                    chk("pre_rst_kw", bus.o_kernel_weight, 5);
                end
                if (bus.s_w_valid && bus.s_w_ready) tap++;
                if (c < 7) begin
                    @(posedge s_clk); #1;
                end
            end
            #2 s_rst = 1'b1;
            #1;
            chk("mid_rst_kwv", bus.o_k_weight_valid, 0);
            chk("mid_rst_kw", bus.o_kernel_weight, 0);
            chk("mid_rst_busy", o_busy, 0);
            chk("mid_rst_w_ready", bus.s_w_ready, 0);
            chk("mid_rst_pix_cnt", o_pix_cnt, 0);
            chk("mid_rst_fd", bus.o_feature_data, 0);
            idle_inputs();
            @(negedge s_clk); s_rst = 1'b0;
            @(posedge s_clk); #1;
            last_fd = '0;
            run_tile(tbl[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
